perceptron_trainer: RTL and testbench

- Downstream consumer of the prediction stage. When a branch resolves, it takes the recorded sum y, the issued prediction and the actual outcome, and decides whether to train.
- If training is needed, it performs a serial read-modify-write of every weight in the selected perceptron row, using saturating ±1 updates.
- It sits between the branch-resolution interface and the weight table SRAM/regfile.

---
 rtl/perceptron_trainer_pkg.sv | 29 ++
 rtl/perceptron_trainer_sat_incdec.sv | 22 ++
 rtl/perceptron_trainer.sv | 117 +++++++++++
 tb/tb_perceptron_trainer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_trainer_pkg.sv
// Shared constants, types and resolution-record layout for the perceptron trainer.
package perceptron_trainer_pkg;

  localparam int unsigned HIST_LEN     = 32;
  localparam int unsigned WEIGHT_WIDTH = 8;
  localparam int unsigned IDX_WIDTH    = 10;
  localparam int unsigned COL_WIDTH    = $clog2(HIST_LEN + 1);
  localparam int unsigned Y_WIDTH      = WEIGHT_WIDTH + COL_WIDTH;
  localparam int          THETA        = 75;  // floor(1.93*HIST_LEN + 14)

  typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    READ,
    WRITE,
    DONE
  } trainer_state_e;

  typedef struct packed {
    logic signed [Y_WIDTH-1:0] y;
    logic                      pred;
    logic                      taken;
    logic [HIST_LEN-1:0]       history;
    logic [IDX_WIDTH-1:0]      index;
  } res_rec_t;

endpackage

// File: rtl/perceptron_trainer_sat_incdec.sv
// Combinational saturating +/-1 on a signed weight; a saturated weight passes through unchanged.
module sat_incdec
  import perceptron_trainer_pkg::*;
(
  input  logic signed [WEIGHT_WIDTH-1:0] i_w,
  input  logic                           i_inc,
  output logic signed [WEIGHT_WIDTH-1:0] o_w
);

  localparam weight_t W_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
  localparam weight_t W_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

  always_comb begin
    o_w = i_w;
    if (i_inc) begin
      if (i_w != W_MAX) o_w = i_w + weight_t'(1);
    end else begin
      if (i_w != W_MIN) o_w = i_w - weight_t'(1);
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Branch-resolution trainer: decides whether to train and serially read-modify-writes
// every weight of the selected perceptron row with saturating +/-1 updates.
module perceptron_trainer
  import perceptron_trainer_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           res_valid,
  output logic                           res_ready,
  input  logic signed [Y_WIDTH-1:0]      res_y,
  input  logic                           res_pred,
  input  logic                           res_taken,
  input  logic [HIST_LEN-1:0]            res_history,
  input  logic [IDX_WIDTH-1:0]           res_index,
  output logic                           wt_re,
  output logic                           wt_we,
  output logic [IDX_WIDTH-1:0]           wt_row,
  output logic [COL_WIDTH-1:0]           wt_col,
  input  logic signed [WEIGHT_WIDTH-1:0] wt_rdata,
  output logic signed [WEIGHT_WIDTH-1:0] wt_wdata,
  output logic                           train_done,
  output logic                           trained
);

  localparam logic signed [Y_WIDTH:0] THETA_POS = (Y_WIDTH+1)'(THETA);
  localparam logic signed [Y_WIDTH:0] THETA_NEG = -THETA_POS;

  trainer_state_e r_state;
  res_rec_t       r_rec;

  logic signed [Y_WIDTH:0] w_y_ext;
  logic                    w_train;
  logic [HIST_LEN:0]       w_x_vec;
  logic                    w_x;
  weight_t                 w_new;

  // One extra bit keeps the most-negative y from wrapping in the magnitude test.
  assign w_y_ext = {r_rec.y[Y_WIDTH-1], r_rec.y};
  assign w_train = (r_rec.pred != r_rec.taken) ||
                   ((w_y_ext >= THETA_NEG) && (w_y_ext <= THETA_POS));

  // Column 0 is the bias (input 1); column c>0 uses history bit c-1.
  assign w_x_vec = {r_rec.history, 1'b1};
  assign w_x     = w_x_vec[wt_col];

  sat_incdec u_sat (
    .i_w   (wt_rdata),
    .i_inc (r_rec.taken == w_x),
    .o_w   (w_new)
  );

  // Read data only arrives in WRITE, so the write strobe/data decode from the state register.
  assign wt_we    = (r_state == WRITE);
  assign wt_wdata = wt_we ? w_new : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rec      <= '0;
      res_ready  <= 1'b1;
      wt_re      <= 1'b0;
      wt_row     <= '0;
      wt_col     <= '0;
      train_done <= 1'b0;
      trained    <= 1'b0;
    end else begin
      wt_re      <= 1'b0;
      train_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (res_valid && res_ready) begin
            r_rec     <= '{y: res_y, pred: res_pred, taken: res_taken,
                           history: res_history, index: res_index};
            res_ready <= 1'b0;
            r_state   <= DECIDE;
          end
        end
        DECIDE: begin
          if (w_train) begin
            wt_re   <= 1'b1;
            wt_row  <= r_rec.index;
            wt_col  <= '0;
            r_state <= READ;
          end else begin
            trained    <= 1'b0;
            train_done <= 1'b1;
            r_state    <= DONE;
          end
        end
        READ: begin
          r_state <= WRITE;
        end
        WRITE: begin
          if (wt_col == COL_WIDTH'(HIST_LEN)) begin
            trained    <= 1'b1;
            train_done <= 1'b1;
            r_state    <= DONE;
          end else begin
            wt_col  <= wt_col + COL_WIDTH'(1);
            wt_re   <= 1'b1;
            r_state <= READ;
          end
        end
        DONE: begin
          trained   <= 1'b0;
          res_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          res_ready <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomized self-checking bench: SRAM model plus a whole-row arithmetic reference of the training rule.
module tb_perceptron_trainer;
  import perceptron_trainer_pkg::*;

  logic                           clk;
  logic                           rst;
  logic                           res_valid;
  logic                           res_ready;
  logic signed [Y_WIDTH-1:0]      res_y;
  logic                           res_pred;
  logic                           res_taken;
  logic [HIST_LEN-1:0]            res_history;
  logic [IDX_WIDTH-1:0]           res_index;
  logic                           wt_re;
  logic                           wt_we;
  logic [IDX_WIDTH-1:0]           wt_row;
  logic [COL_WIDTH-1:0]           wt_col;
  logic signed [WEIGHT_WIDTH-1:0] wt_rdata;
  logic signed [WEIGHT_WIDTH-1:0] wt_wdata;
  logic                           train_done;
  logic                           trained;

  logic signed [7:0] mem     [1024][33];
  logic signed [7:0] exp_mem [1024][33];

  int checks = 0;
  int errors = 0;

  perceptron_trainer dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_y      (res_y),
    .res_pred   (res_pred),
    .res_taken  (res_taken),
    .res_history(res_history),
    .res_index  (res_index),
    .wt_re      (wt_re),
    .wt_we      (wt_we),
    .wt_row     (wt_row),
    .wt_col     (wt_col),
    .wt_rdata   (wt_rdata),
    .wt_wdata   (wt_wdata),
    .train_done (train_done),
    .trained    (trained)
  );

  always #5 clk = ~clk;

  // Weight SRAM: read data appears the cycle after wt_re.
  always @(posedge clk) begin
    if (wt_we) mem[wt_row][wt_col] <= wt_wdata;
    if (wt_re) wt_rdata <= mem[wt_row][wt_col];
  end

  function automatic bit should_train(int y, bit pred, bit taken);
    return (pred != taken) || (y >= -75 && y <= 75);
  endfunction

  task automatic apply_model(int idx, logic [31:0] hist, bit taken, int ncols);
    for (int c = 0; c < ncols; c++) begin
      int w;
      bit x;
      x = (c == 0) ? 1'b1 : hist[c-1];
      w = int'(exp_mem[idx][c]);
      if (taken == x) w = (w < 127) ? w + 1 : w;
      else            w = (w > -128) ? w - 1 : w;
      exp_mem[idx][c] = 8'(w);
    end
  endtask

  function automatic int row_bad(int idx);
    int n = 0;
    for (int c = 0; c < 33; c++) if (mem[idx][c] !== exp_mem[idx][c]) n++;
    return n;
  endfunction

  task automatic drive(int y, bit pred, bit taken, logic [31:0] hist, int idx);
    res_y       = Y_WIDTH'(y);
    res_pred    = pred;
    res_taken   = taken;
    res_history = hist;
    res_index   = IDX_WIDTH'(idx);
  endtask

  // Counts cycles after an accept edge until train_done, tallying strobes on the way.
  task automatic wait_done(output int lat, output bit trn, output int nre, output int nwe,
                           output int novl, output int nrdy);
    lat = -1; trn = 1'b0; nre = 0; nwe = 0; novl = 0; nrdy = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (wt_re) nre++;
      if (wt_we) nwe++;
      if (wt_re && wt_we) novl++;
      if (res_ready) nrdy++;
      if (train_done) begin
        lat = c;
        trn = trained;
        break;
      end
    end
  endtask

  task automatic run_record(int y, bit pred, bit taken, logic [31:0] hist, int idx,
                            output int lat, output bit trn, output int nre, output int nwe,
                            output int novl);
    int nrdy;
    @(negedge clk);
    drive(y, pred, taken, hist, idx);
    res_valid = 1'b1;
    @(posedge clk);
    #1 res_valid = 1'b0;
    wait_done(lat, trn, nre, nwe, novl, nrdy);
    if (should_train(y, pred, taken)) apply_model(idx, hist, taken, 33);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", res_ready); end
    checks++; if ({wt_re, wt_we} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {wt_re, wt_we}); end
    checks++; if ({train_done, trained} !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", {train_done, trained}); end
    checks++; if (wt_row !== '0 || wt_col !== '0 || wt_wdata !== '0) begin
      errors++; $display("FAIL reset_addr got row %0d col %0d wdata %0d want 0 0 0", wt_row, wt_col, wt_wdata);
    end
  endtask

  task automatic test_no_train();
    int lat, nre, nwe, novl; bit trn;
    run_record(100, 1'b1, 1'b1, 32'h1234_5678, 1, lat, trn, nre, nwe, novl);
    checks++; if (lat !== 2) begin errors++; $display("FAIL no_train_latency got %0d want 2", lat); end
    checks++; if (trn !== 1'b0) begin errors++; $display("FAIL no_train_trained got %0b want 0", trn); end
    checks++; if (nre + nwe !== 0) begin errors++; $display("FAIL no_train_strobes got %0d want 0", nre + nwe); end
    checks++; if (row_bad(1) !== 0) begin errors++; $display("FAIL no_train_row got %0d bad cols want 0", row_bad(1)); end
  endtask

  task automatic test_mispredict();
    int lat, nre, nwe, novl, n_not_one; bit trn;
    for (int c = 0; c < 33; c++) begin mem[5][c] = 8'sd0; exp_mem[5][c] = 8'sd0; end
    run_record(-5, 1'b0, 1'b1, 32'hFFFF_FFFF, 5, lat, trn, nre, nwe, novl);
    n_not_one = 0;
    for (int c = 0; c < 33; c++) if (mem[5][c] !== 8'sd1) n_not_one++;
    checks++; if (lat !== 68) begin errors++; $display("FAIL mispredict_latency got %0d want 68", lat); end
    checks++; if (trn !== 1'b1) begin errors++; $display("FAIL mispredict_trained got %0b want 1", trn); end
    checks++; if (nre !== 33 || nwe !== 33) begin errors++; $display("FAIL mispredict_pairs got re %0d we %0d want 33 33", nre, nwe); end
    checks++; if (novl !== 0) begin errors++; $display("FAIL mispredict_overlap got %0d want 0", novl); end
    checks++; if (n_not_one !== 0) begin errors++; $display("FAIL mispredict_row got %0d cols not +1 want 0", n_not_one); end
  endtask

  task automatic test_theta();
    int lat, nre, nwe, novl; bit trn;
    int ys[4] = '{75, -76, -75, 76};
    bit ps[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      bit want;
      want = should_train(ys[k], ps[k], ps[k]);
      run_record(ys[k], ps[k], ps[k], $urandom, 7, lat, trn, nre, nwe, novl);
      checks++; if (trn !== want) begin errors++; $display("FAIL theta_trained y=%0d got %0b want %0b", ys[k], trn, want); end
      checks++; if (lat !== (want ? 68 : 2)) begin errors++; $display("FAIL theta_latency y=%0d got %0d want %0d", ys[k], lat, want ? 68 : 2); end
      checks++; if (row_bad(7) !== 0) begin errors++; $display("FAIL theta_row y=%0d got %0d bad cols want 0", ys[k], row_bad(7)); end
    end
  endtask

  task automatic test_saturation();
    int lat, nre, nwe, novl, nsat_bad; bit trn;
    logic [31:0] hist = 32'hAAAA_AAAA;
    for (int c = 0; c < 33; c++) begin
      logic signed [7:0] w;
      w = (c % 3 == 0) ? 8'sd127 : (c % 3 == 1) ? -8'sd128 : 8'($urandom);
      mem[9][c] = w; exp_mem[9][c] = w;
    end
    run_record(0, 1'b0, 1'b1, hist, 9, lat, trn, nre, nwe, novl);
    nsat_bad = 0;
    for (int c = 0; c < 33; c++) begin
      bit x;
      x = (c == 0) ? 1'b1 : hist[c-1];
      if (c % 3 == 0 && x && mem[9][c] !== 8'sd127) nsat_bad++;
      if (c % 3 == 1 && !x && mem[9][c] !== -8'sd128) nsat_bad++;
    end
    checks++; if (trn !== 1'b1) begin errors++; $display("FAIL sat_trained got %0b want 1", trn); end
    checks++; if (nsat_bad !== 0) begin errors++; $display("FAIL sat_clamp got %0d bad cols want 0", nsat_bad); end
    checks++; if (row_bad(9) !== 0) begin errors++; $display("FAIL sat_row got %0d bad cols want 0", row_bad(9)); end
  endtask

  task automatic test_extreme();
    int lat, nre, nwe, novl; bit trn;
    run_record(-8192, 1'b0, 1'b0, $urandom, 4, lat, trn, nre, nwe, novl);
    checks++; if (trn !== 1'b0 || lat !== 2) begin errors++; $display("FAIL extreme_neg got trained %0b lat %0d want 0 2", trn, lat); end
    checks++; if (nre + nwe !== 0) begin errors++; $display("FAIL extreme_neg_strobes got %0d want 0", nre + nwe); end
    run_record(8191, 1'b1, 1'b1, $urandom, 4, lat, trn, nre, nwe, novl);
    checks++; if (trn !== 1'b0 || lat !== 2) begin errors++; $display("FAIL extreme_pos got trained %0b lat %0d want 0 2", trn, lat); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      int lat, nre, nwe, novl, y, idx; bit trn, p, t, want;
      y = int'($urandom_range(240)) - 120;
      p = 1'($urandom); t = 1'($urandom);
      idx = int'($urandom_range(15));
      want = should_train(y, p, t);
      run_record(y, p, t, $urandom, idx, lat, trn, nre, nwe, novl);
      checks++; if (trn !== want || lat !== (want ? 68 : 2)) begin
        errors++; $display("FAIL random_%0d got trained %0b lat %0d want %0b %0d", k, trn, lat, want, want ? 68 : 2);
      end
      checks++; if (row_bad(idx) !== 0 || novl !== 0) begin
        errors++; $display("FAIL random_row_%0d got %0d bad cols %0d overlaps want 0 0", k, row_bad(idx), novl);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nre, nwe, novl, nrdy; bit trn;
    logic [31:0] hb = $urandom;
    @(negedge clk);
    drive(200, 1'b1, 1'b1, $urandom, 2);
    res_valid = 1'b1;
    @(posedge clk);
    wait_done(lat, trn, nre, nwe, novl, nrdy);
    checks++; if (lat !== 2 || nrdy !== 0) begin errors++; $display("FAIL b2b_first got lat %0d ready_cycles %0d want 2 0", lat, nrdy); end
    drive(10, 1'b1, 1'b1, hb, 3);
    @(negedge clk);
    checks++; if (res_ready !== 1'b1 || train_done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got ready %0b done %0b want 1 0", res_ready, train_done);
    end
    @(posedge clk);
    #1 res_valid = 1'b0;
    wait_done(lat, trn, nre, nwe, novl, nrdy);
    apply_model(3, hb, 1'b1, 33);
    checks++; if (lat !== 68 || trn !== 1'b1 || nrdy !== 0) begin
      errors++; $display("FAIL b2b_second got lat %0d trained %0b ready_cycles %0d want 68 1 0", lat, trn, nrdy);
    end
    checks++; if (row_bad(3) !== 0) begin errors++; $display("FAIL b2b_row got %0d bad cols want 0", row_bad(3)); end
  endtask

  task automatic test_reset_mid();
    int nw, nstrobe;
    logic [31:0] h = $urandom;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, h, 11);
    res_valid = 1'b1;
    @(posedge clk);
    #1 res_valid = 1'b0;
    nw = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wt_we) begin nw++; if (nw == 5) break; end
    end
    checks++; if (nw !== 5) begin errors++; $display("FAIL rst_mid_reach got %0d writes want 5", nw); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    apply_model(11, h, 1'b1, 5);
    @(negedge clk);
    checks++; if (res_ready !== 1'b1 || wt_re !== 1'b0 || wt_we !== 1'b0 || train_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got ready %0b re %0b we %0b done %0b want 1 0 0 0", res_ready, wt_re, wt_we, train_done);
    end
    nstrobe = 0;
    repeat (6) begin @(negedge clk); if (wt_re || wt_we || train_done) nstrobe++; end
    checks++; if (nstrobe !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d strobe cycles want 0", nstrobe); end
    checks++; if (row_bad(11) !== 0) begin errors++; $display("FAIL rst_mid_row got %0d bad cols want 0", row_bad(11)); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    res_valid = 1'b0;
    wt_rdata = '0;
    drive(0, 1'b0, 1'b0, 32'h0, 0);
    for (int r = 0; r < 1024; r++)
      for (int c = 0; c < 33; c++) begin
        logic signed [7:0] w;
        w = (r < 16) ? 8'($urandom) : 8'sd0;
        mem[r][c] = w;
        exp_mem[r][c] = w;
      end
    test_reset();
    test_no_train();
    test_mispredict();
    test_theta();
    test_saturation();
    test_extreme();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
